// File: rtl/tx_pause_pkg.sv
// Shared definitions for the TX pause scheduler: FSM encoding, frame kinds, default widths.
// Statistics counters in tx_pause_ctrl are built only when TX_PAUSE_STATS_EN is defined.
package tx_pause_pkg;

    localparam int LVL_W_DEF = 16;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    typedef enum logic {
        KIND_XON  = 1'b0,
        KIND_XOFF = 1'b1
    } kind_e;

endpackage

// File: rtl/tx_pause_refresh_tmr.sv
// XOFF refresh timer: loaded with the period on entry to PAUSED, counts down while enabled,
// pulses expire on the last cycle of the period and sits at zero afterwards (period 0 never fires).
module tx_pause_refresh_tmr
    import tx_pause_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [LVL_W-1:0] intv,
    output logic             expire
);

    logic [LVL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= intv;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - LVL_W'(1);
        end
    end

    assign expire = en && (cnt == LVL_W'(1));

endmodule

// File: rtl/tx_pause_ctrl.sv
// Pause-frame scheduler for the TX path: threshold/software driven XOFF/XON with refresh.
// Define TX_PAUSE_STATS_EN to build the xoff_cnt/xon_cnt statistics counters.
//
// state  | meaning
// IDLE   | no pause in force
// SEND   | xreq high, waiting for xdone
// PAUSED | XOFF in force, refresh timer running
module tx_pause_ctrl
    import tx_pause_pkg::*;
#(
    parameter int LVL_W = LVL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fc_en,
    input  logic [LVL_W-1:0] rxbuf_level,
    input  logic [LVL_W-1:0] xoff_thresh,
    input  logic [LVL_W-1:0] xon_thresh,
    input  logic [LVL_W-1:0] refresh_intv,
    input  logic             sw_xreq,
    input  logic             sw_xon,
    input  logic             xdone,
    output logic             xreq,
    output logic             xon,
    output logic             paused,
    output logic             sw_busy,
    output logic [CNT_W-1:0] xoff_cnt,
    output logic [CNT_W-1:0] xon_cnt,
    input  logic             stat_clr
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SEND   = ST_SEND;
    localparam logic [1:0] S_PAUSED = ST_PAUSED;

    logic [1:0] state, state_nx;
    logic       go, kind_nx, sw_take, sw_drop;
    logic       sw_pend, sw_kind, sw_fly;
    logic       thr_xoff, thr_xon, done, tmr_exp;

    // XOFF level wins when the thresholds overlap
    assign thr_xoff = fc_en && (rxbuf_level >= xoff_thresh);
    assign thr_xon  = fc_en && (rxbuf_level <= xon_thresh) && !(rxbuf_level >= xoff_thresh);
    assign done     = (state == S_SEND) && xdone;

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        kind_nx  = xon;
        sw_take  = 1'b0;
        sw_drop  = 1'b0;
        case (state)
            S_IDLE: begin
                if (thr_xoff) begin
                    go      = 1'b1;
                    kind_nx = KIND_XOFF;
                end else if (sw_pend) begin
                    if (sw_kind == KIND_XOFF) begin
                        go      = 1'b1;
                        kind_nx = KIND_XOFF;
                        sw_take = 1'b1;
                    end else begin
                        sw_drop = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (sw_pend && (sw_kind == KIND_XOFF)) sw_drop = 1'b1;
                if (xdone) state_nx = (xon == KIND_XOFF) ? S_PAUSED : S_IDLE;
            end
            S_PAUSED: begin
                if (thr_xon) begin
                    go      = 1'b1;
                    kind_nx = KIND_XON;
                end else if (sw_pend) begin
                    go      = 1'b1;
                    kind_nx = sw_kind;
                    sw_take = 1'b1;
                end else if (tmr_exp) begin
                    go      = 1'b1;
                    kind_nx = KIND_XOFF;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (go) state_nx = S_SEND;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            xreq    <= 1'b0;
            xon     <= 1'b0;
            paused  <= 1'b0;
            sw_pend <= 1'b0;
            sw_kind <= 1'b0;
            sw_fly  <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                xreq <= 1'b1;
                xon  <= kind_nx;
            end else if (done) begin
                xreq <= 1'b0;
            end
            if (done) begin
                paused <= xon;
                sw_fly <= 1'b0;
            end
            if (sw_take) sw_fly <= 1'b1;
            // a fresh request overwrites whatever is pending, even one being consumed now
            if (sw_xreq) begin
                sw_pend <= 1'b1;
                sw_kind <= sw_xon;
            end else if (sw_take || sw_drop) begin
                sw_pend <= 1'b0;
            end
        end
    end

    assign sw_busy = sw_pend | sw_fly;

    tx_pause_refresh_tmr #(.LVL_W(LVL_W)) u_refresh (
        .clk    (clk),
        .rst    (rst),
        .clr    (done && (xon == KIND_XOFF)),
        .en     (state == S_PAUSED),
        .intv   (refresh_intv),
        .expire (tmr_exp)
    );

`ifdef TX_PAUSE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            xoff_cnt <= '0;
            xon_cnt  <= '0;
        end else if (done) begin
            if (xon == KIND_XOFF) xoff_cnt <= xoff_cnt + CNT_W'(1);
            else                  xon_cnt  <= xon_cnt + CNT_W'(1);
        end
    end
`else
    logic stats_unused;
    assign stats_unused = stat_clr;
    assign xoff_cnt     = '0;
    assign xon_cnt      = '0;
`endif

endmodule

// File: tb/tb_tx_pause_ctrl.sv
// Bench for tx_pause_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_tx_pause_ctrl;

    localparam int LVL_W = 16;
    localparam int CNT_W = 32;
`ifdef TX_PAUSE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fc_en = 1'b0;
    logic [LVL_W-1:0] rxbuf_level = '0;
    logic [LVL_W-1:0] xoff_thresh = 16'd200;
    logic [LVL_W-1:0] xon_thresh = 16'd50;
    logic [LVL_W-1:0] refresh_intv = '0;
    logic             sw_xreq = 1'b0;
    logic             sw_xon = 1'b0;
    logic             xdone = 1'b0;
    logic             stat_clr = 1'b0;
    logic             xreq, xon, paused, sw_busy;
    logic [CNT_W-1:0] xoff_cnt, xon_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model: peer pause flag + frame in flight + one-deep software slot
    bit m_xreq, m_xon, m_paused, m_pend, m_pkind, m_fly, m_swb;
    int m_age, m_nxoff, m_nxon;

    bit auto_done = 1'b1;
    bit spur_en = 1'b0;
    int enc_wait = 0;

    tx_pause_ctrl #(.LVL_W(LVL_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fc_en        (fc_en),
        .rxbuf_level  (rxbuf_level),
        .xoff_thresh  (xoff_thresh),
        .xon_thresh   (xon_thresh),
        .refresh_intv (refresh_intv),
        .sw_xreq      (sw_xreq),
        .sw_xon       (sw_xon),
        .xdone        (xdone),
        .xreq         (xreq),
        .xon          (xon),
        .paused       (paused),
        .sw_busy      (sw_busy),
        .xoff_cnt     (xoff_cnt),
        .xon_cnt      (xon_cnt),
        .stat_clr     (stat_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        return STATS ? CNT_W'(n) : '0;
    endfunction

    task automatic model_step();
        bit go = 1'b0;
        bit gk = 1'b0;
        bit take = 1'b0;
        bit drop = 1'b0;
        bit fin = 1'b0;
        if (rst) begin
            m_xreq = 0; m_xon = 0; m_paused = 0; m_pend = 0; m_pkind = 0;
            m_fly = 0; m_swb = 0; m_age = 0; m_nxoff = 0; m_nxon = 0;
            return;
        end
        if (m_xreq) begin
            if (m_pend && m_pkind) drop = 1'b1;
            if (xdone) fin = 1'b1;
        end else if (!m_paused) begin
            if (fc_en && rxbuf_level >= xoff_thresh) begin
                go = 1'b1; gk = 1'b1;
            end else if (m_pend) begin
                if (m_pkind) begin go = 1'b1; gk = 1'b1; take = 1'b1; end
                else drop = 1'b1;
            end
        end else begin
            if (fc_en && rxbuf_level <= xon_thresh && rxbuf_level < xoff_thresh) begin
                go = 1'b1; gk = 1'b0;
            end else if (m_pend) begin
                go = 1'b1; gk = m_pkind; take = 1'b1;
            end else if (refresh_intv != 0 && m_age == int'(refresh_intv) - 1) begin
                go = 1'b1; gk = 1'b1;
            end
            m_age++;
        end
        if (fin) begin
            if (m_xon) m_nxoff++;
            else m_nxon++;
            m_paused = m_xon;
            m_xreq = 1'b0;
            m_fly = 1'b0;
            m_age = 0;
        end
        if (go) begin m_xreq = 1'b1; m_xon = gk; end
        if (take) m_fly = 1'b1;
        if (sw_xreq) begin m_pend = 1'b1; m_pkind = sw_xon; end
        else if (take || drop) m_pend = 1'b0;
        if (stat_clr) begin m_nxoff = 0; m_nxon = 0; end
        m_swb = m_pend || m_fly;
    endtask

    // one clock: model follows the edge, then pulses are retired and the encap reacts
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        sw_xreq = 1'b0;
        stat_clr = 1'b0;
        xdone = 1'b0;
        if (auto_done && m_xreq) begin
            if (enc_wait == 0) begin
                xdone = 1'b1;
                enc_wait = $urandom_range(0, 6);
            end else begin
                enc_wait--;
            end
        end else if (spur_en && !m_xreq && $urandom_range(0, 9) == 0) begin
            xdone = 1'b1;
        end
    endtask

    task automatic wait_xreq_low(input string tag);
        int n = 0;
        while (xreq === 1'b1 && n < 60) begin tick(); n++; end
        checks++;
        if (xreq !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout xreq=%b required=0", tag, xreq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (xreq !== 1'b0)    begin errors++; $display("FAIL rst_xreq got=%b exp=0", xreq); end
        if (xon !== 1'b0)     begin errors++; $display("FAIL rst_xon got=%b exp=0", xon); end
        if (paused !== 1'b0)  begin errors++; $display("FAIL rst_paused got=%b exp=0", paused); end
        if (sw_busy !== 1'b0) begin errors++; $display("FAIL rst_sw_busy got=%b exp=0", sw_busy); end
        if (xoff_cnt !== '0)  begin errors++; $display("FAIL rst_xoff_cnt got=%0d exp=0", xoff_cnt); end
        if (xon_cnt !== '0)   begin errors++; $display("FAIL rst_xon_cnt got=%0d exp=0", xon_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_threshold();
        int hi = 0;
        fc_en = 1'b1; xoff_thresh = 16'd200; xon_thresh = 16'd50; refresh_intv = '0;
        rxbuf_level = '0;
        repeat (3) tick();
        enc_wait = 9;
        rxbuf_level = 16'd200;
        tick();
        checks++;
        if (xreq !== 1'b1 || xon !== 1'b1) begin
            errors++; $display("FAIL thr_xoff_rise xreq=%b xon=%b exp=1,1", xreq, xon);
        end
        for (int i = 0; i < 40 && xreq === 1'b1; i++) begin hi++; tick(); end
        checks += 3;
        if (hi != 10) begin errors++; $display("FAIL thr_xoff_len got=%0d exp=10", hi); end
        if (paused !== 1'b1) begin errors++; $display("FAIL thr_paused got=%b exp=1", paused); end
        if (xoff_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL thr_xoff_cnt got=%0d exp=%0d", xoff_cnt, exp_cnt(1));
        end
        rxbuf_level = 16'd120;
        repeat (5) tick();
        checks++;
        if (xreq !== 1'b0 || paused !== 1'b1) begin
            errors++; $display("FAIL thr_hyst xreq=%b paused=%b exp=0,1", xreq, paused);
        end
        rxbuf_level = 16'd50;
        tick();
        checks++;
        if (xreq !== 1'b1 || xon !== 1'b0) begin
            errors++; $display("FAIL thr_xon_rise xreq=%b xon=%b exp=1,0", xreq, xon);
        end
        wait_xreq_low("thr_xon");
        checks += 2;
        if (paused !== 1'b0) begin errors++; $display("FAIL thr_unpaused got=%b exp=0", paused); end
        if (xon_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL thr_xon_cnt got=%0d exp=%0d", xon_cnt, exp_cnt(1));
        end
        rxbuf_level = '0;
        tick();
    endtask

    task automatic test_refresh();
        int gap, rises;
        bit prev;
        refresh_intv = 16'd100;
        rxbuf_level = 16'd200;
        tick();
        rxbuf_level = 16'd150;
        wait_xreq_low("ref_first");
        for (int r = 0; r < 2; r++) begin
            gap = 0;
            while (xreq === 1'b0 && gap < 300) begin gap++; tick(); end
            checks += 2;
            if (gap != 100) begin errors++; $display("FAIL ref_gap%0d got=%0d exp=100", r, gap); end
            if (xon !== 1'b1) begin errors++; $display("FAIL ref_kind%0d got=%b exp=1", r, xon); end
            if (r == 1) refresh_intv = '0;
            wait_xreq_low("ref_frame");
        end
        rises = 0;
        prev = xreq;
        repeat (250) begin
            tick();
            if (xreq === 1'b1 && !prev) rises++;
            prev = xreq;
        end
        checks += 2;
        if (rises != 0) begin errors++; $display("FAIL ref_disabled rises=%0d exp=0", rises); end
        if (paused !== 1'b1) begin errors++; $display("FAIL ref_paused got=%b exp=1", paused); end
        rxbuf_level = '0;
        tick();
        wait_xreq_low("ref_xon");
        tick();
    endtask

    task automatic test_sw_merge();
        int rises = 0;
        bit prev;
        refresh_intv = '0;
        rxbuf_level = 16'd200;
        sw_xreq = 1'b1; sw_xon = 1'b1;
        tick();
        checks++;
        if (xreq !== 1'b1 || xon !== 1'b1 || sw_busy !== 1'b1) begin
            errors++; $display("FAIL sw_merge_rise xreq=%b xon=%b busy=%b exp=1,1,1", xreq, xon, sw_busy);
        end
        tick();
        checks++;
        if (sw_busy !== 1'b0) begin errors++; $display("FAIL sw_merge_drop busy=%b exp=0", sw_busy); end
        rxbuf_level = 16'd150;
        prev = xreq;
        repeat (30) begin
            tick();
            if (xreq === 1'b1 && !prev) rises++;
            prev = xreq;
        end
        checks += 2;
        if (rises != 0) begin errors++; $display("FAIL sw_merge_single extra=%0d exp=0", rises); end
        if (paused !== 1'b1) begin errors++; $display("FAIL sw_merge_paused got=%b exp=1", paused); end
        sw_xreq = 1'b1; sw_xon = 1'b0;
        tick();
        checks++;
        if (sw_busy !== 1'b1 || xreq !== 1'b0) begin
            errors++; $display("FAIL sw_xon_pend busy=%b xreq=%b exp=1,0", sw_busy, xreq);
        end
        tick();
        checks++;
        if (xreq !== 1'b1 || xon !== 1'b0 || sw_busy !== 1'b1) begin
            errors++; $display("FAIL sw_xon_send xreq=%b xon=%b busy=%b exp=1,0,1", xreq, xon, sw_busy);
        end
        wait_xreq_low("sw_xon");
        checks++;
        if (sw_busy !== 1'b0 || paused !== 1'b0) begin
            errors++; $display("FAIL sw_xon_done busy=%b paused=%b exp=0,0", sw_busy, paused);
        end
        sw_xreq = 1'b1; sw_xon = 1'b0;
        tick();
        tick();
        checks++;
        if (sw_busy !== 1'b0 || xreq !== 1'b0) begin
            errors++; $display("FAIL sw_idle_xon_drop busy=%b xreq=%b exp=0,0", sw_busy, xreq);
        end
        fc_en = 1'b0; rxbuf_level = 16'd300;
        sw_xreq = 1'b1; sw_xon = 1'b1;
        tick();
        tick();
        checks++;
        if (xreq !== 1'b1 || xon !== 1'b1) begin
            errors++; $display("FAIL sw_xoff_send xreq=%b xon=%b exp=1,1", xreq, xon);
        end
        wait_xreq_low("sw_xoff");
        rxbuf_level = '0;
        repeat (10) tick();
        checks++;
        if (paused !== 1'b1 || sw_busy !== 1'b0 || xreq !== 1'b0) begin
            errors++; $display("FAIL sw_fc_off_hold paused=%b busy=%b xreq=%b exp=1,0,0", paused, sw_busy, xreq);
        end
        sw_xreq = 1'b1; sw_xon = 1'b0;
        for (int i = 0; i < 40 && paused !== 1'b0; i++) tick();
        checks++;
        if (paused !== 1'b0) begin errors++; $display("FAIL sw_release paused=%b exp=0", paused); end
        fc_en = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_send();
        rxbuf_level = 16'd200;
        enc_wait = 20;
        tick();
        checks++;
        if (xreq !== 1'b1) begin errors++; $display("FAIL rms_rise xreq=%b exp=1", xreq); end
        rxbuf_level = '0;
        rst = 1'b1;
        tick();
        checks++;
        if (xreq !== 1'b0 || xon !== 1'b0 || paused !== 1'b0 || sw_busy !== 1'b0) begin
            errors++; $display("FAIL rms_reset xreq=%b xon=%b paused=%b busy=%b exp=0,0,0,0", xreq, xon, paused, sw_busy);
        end
        rst = 1'b0;
        auto_done = 1'b0;
        xdone = 1'b1;
        tick();
        checks++;
        if (xreq !== 1'b0 || paused !== 1'b0 || xoff_cnt !== '0 || xon_cnt !== '0) begin
            errors++; $display("FAIL rms_stray_xdone xreq=%b paused=%b xoff_cnt=%0d xon_cnt=%0d exp=0,0,0,0", xreq, paused, xoff_cnt, xon_cnt);
        end
        auto_done = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_stats();
        rxbuf_level = 16'd200; tick(); wait_xreq_low("st_a");
        rxbuf_level = 16'd0;   tick(); wait_xreq_low("st_b");
        rxbuf_level = 16'd200; tick(); wait_xreq_low("st_c");
        checks += 2;
        if (xoff_cnt !== exp_cnt(2)) begin
            errors++; $display("FAIL stats_xoff got=%0d exp=%0d", xoff_cnt, exp_cnt(2));
        end
        if (xon_cnt !== exp_cnt(1)) begin
            errors++; $display("FAIL stats_xon got=%0d exp=%0d", xon_cnt, exp_cnt(1));
        end
        stat_clr = 1'b1;
        tick();
        checks++;
        if (xoff_cnt !== '0 || xon_cnt !== '0) begin
            errors++; $display("FAIL stats_clr xoff=%0d xon=%0d exp=0,0", xoff_cnt, xon_cnt);
        end
        rxbuf_level = '0; tick(); wait_xreq_low("st_d");
    endtask

    task automatic test_random();
        int lvl = 0;
        int xo;
        spur_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                xo = $urandom_range(40, 300);
                xoff_thresh = LVL_W'(xo);
                xon_thresh = ($urandom_range(0, 4) == 0) ? LVL_W'($urandom_range(xo, xo + 30))
                                                          : LVL_W'($urandom_range(0, xo - 1));
                fc_en = ($urandom_range(0, 7) != 0);
            end
            if (!m_paused && $urandom_range(0, 99) == 0)
                refresh_intv = ($urandom_range(0, 3) == 0) ? '0 : LVL_W'($urandom_range(1, 40));
            lvl = lvl + int'($urandom_range(0, 24)) - 12;
            if (lvl < 0) lvl = 0;
            if (lvl > 400) lvl = 400;
            rxbuf_level = LVL_W'(lvl);
            if ($urandom_range(0, 29) == 0) begin
                sw_xreq = 1'b1;
                sw_xon = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) stat_clr = 1'b1;
            rst = ($urandom_range(0, 999) == 0);
            tick();
            checks += 6;
            if (xreq !== m_xreq) begin errors++; $display("FAIL rnd_xreq c=%0d got=%b exp=%b", c, xreq, m_xreq); end
            if (xon !== m_xon) begin errors++; $display("FAIL rnd_xon c=%0d got=%b exp=%b", c, xon, m_xon); end
            if (paused !== m_paused) begin errors++; $display("FAIL rnd_paused c=%0d got=%b exp=%b", c, paused, m_paused); end
            if (sw_busy !== m_swb) begin errors++; $display("FAIL rnd_sw_busy c=%0d got=%b exp=%b", c, sw_busy, m_swb); end
            if (xoff_cnt !== exp_cnt(m_nxoff)) begin
                errors++; $display("FAIL rnd_xoff_cnt c=%0d got=%0d exp=%0d", c, xoff_cnt, exp_cnt(m_nxoff));
            end
            if (xon_cnt !== exp_cnt(m_nxon)) begin
                errors++; $display("FAIL rnd_xon_cnt c=%0d got=%0d exp=%0d", c, xon_cnt, exp_cnt(m_nxon));
            end
        end
        rst = 1'b0;
        spur_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_refresh();
        test_sw_merge();
        test_reset_mid_send();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
